// File: rtl/reg_file_2w.sv
// Purpose: 2-read / 2-write register file with write-through bypass, optional hardwired-zero r0 and a busy scoreboard.
// Latency: reads and busy flags are combinational (0 cycles); writes and marks land in storage on the next rising edge.
// Backpressure: none; both write ports and the mark port are accepted on every cycle.
module reg_file_2w #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] reg_a,
    input  logic [ADDR_W-1:0] reg_b,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    output logic              busy_a,
    output logic              busy_b,
    input  logic              we0,
    input  logic [ADDR_W-1:0] reg_w0,
    input  logic [DATA_W-1:0] bus_w0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] reg_w1,
    input  logic [DATA_W-1:0] bus_w1,
    input  logic              mark_en,
    input  logic [ADDR_W-1:0] mark_reg
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Writes and marks aimed at a hardwired-zero r0 are dropped up front so
    // neither storage nor the scoreboard ever sees them.
    logic w0_ok;
    logic w1_ok;
    logic mark_ok;

    assign w0_ok   = we0     && !((ZERO_REG != 0) && (reg_w0   == '0));
    assign w1_ok   = we1     && !((ZERO_REG != 0) && (reg_w1   == '0));
    assign mark_ok = mark_en && !((ZERO_REG != 0) && (mark_reg == '0));

    // Next-state storage: port 0 first, then port 1 so port 1 wins on a shared address.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (w0_ok && (reg_w0 == ADDR_W'(i))) begin
                mem_d[i] = bus_w0;
            end
            if (w1_ok && (reg_w1 == ADDR_W'(i))) begin
                mem_d[i] = bus_w1;
            end
        end
    end

    // Next-state scoreboard: retiring writes clear, a new issue sets last so it wins.
    always_comb begin
        busy_d = busy_q;
        if (w0_ok) begin
            busy_d[reg_w0] = 1'b0;
        end
        if (w1_ok) begin
            busy_d[reg_w1] = 1'b0;
        end
        if (mark_ok) begin
            busy_d[mark_reg] = 1'b1;
        end
    end

    // Storage and busy bits; asynchronous clear drops any same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            busy_q <= busy_d;
        end
    end

    // Read port A: bypass the in-flight write (port 1 first), which also means the
    // value is available so busy is masked; r0 and reset force zeros.
    always_comb begin
        bus_a  = mem_q[reg_a];
        busy_a = busy_q[reg_a];
        if (w1_ok && (reg_w1 == reg_a)) begin
            bus_a  = bus_w1;
            busy_a = 1'b0;
        end else if (w0_ok && (reg_w0 == reg_a)) begin
            bus_a  = bus_w0;
            busy_a = 1'b0;
        end
        if (!rst_n || ((ZERO_REG != 0) && (reg_a == '0))) begin
            bus_a  = '0;
            busy_a = 1'b0;
        end
    end

    // Read port B: identical to port A.
    always_comb begin
        bus_b  = mem_q[reg_b];
        busy_b = busy_q[reg_b];
        if (w1_ok && (reg_w1 == reg_b)) begin
            bus_b  = bus_w1;
            busy_b = 1'b0;
        end else if (w0_ok && (reg_w0 == reg_b)) begin
            bus_b  = bus_w0;
            busy_b = 1'b0;
        end
        if (!rst_n || ((ZERO_REG != 0) && (reg_b == '0))) begin
            bus_b  = '0;
            busy_b = 1'b0;
        end
    end

endmodule
